// File: rtl/msu_pkg.sv
// Shared constants for the multi-channel MSU register engine: register map,
// status-mask bit positions and the read-only identification bytes.
package msu_pkg;

    // Read side of the SNES register window
    localparam logic [3:0] RD_STATUS    = 4'd0;
    localparam logic [3:0] RD_DATA      = 4'd1;
    localparam logic [3:0] RD_CH_SEL    = 4'd8;
    localparam logic [3:0] RD_NUM_CH    = 4'd9;
    localparam logic [3:0] RD_FADE_RATE = 4'd10;

    // Write side of the SNES register window
    localparam logic [3:0] WR_ADDR0     = 4'd0;
    localparam logic [3:0] WR_ADDR1     = 4'd1;
    localparam logic [3:0] WR_ADDR2     = 4'd2;
    localparam logic [3:0] WR_ADDR3     = 4'd3;
    localparam logic [3:0] WR_TRACK_LO  = 4'd4;
    localparam logic [3:0] WR_TRACK_HI  = 4'd5;
    localparam logic [3:0] WR_VOLUME    = 4'd6;
    localparam logic [3:0] WR_CTRL      = 4'd7;
    localparam logic [3:0] WR_CH_SEL    = 4'd8;
    localparam logic [3:0] WR_FADE_RATE = 4'd9;

    // Bit positions inside the MCU status set/reset masks
    localparam int ST_AUDIO      = 5;
    localparam int ST_DATA       = 4;
    localparam int ST_ERROR      = 3;
    localparam int ST_STATUS_HI  = 2;
    localparam int ST_STATUS_LO  = 1;
    localparam int ST_CTRL_START = 0;

    localparam logic [2:0] MSU_REV = 3'b010;

    // "S-MSU1" lives at offsets 2..7; every other offset reads as zero.
    function automatic logic [7:0] id_byte(input logic [3:0] off);
        case (off)
            4'd2:    return 8'h53;
            4'd3:    return 8'h2D;
            4'd4:    return 8'h4D;
            4'd5:    return 8'h53;
            4'd6:    return 8'h55;
            4'd7:    return 8'h31;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/msu_fade_ch.sv
// One audio channel's volume engine: target, current volume, fade rate and
// the tick counter that paces one-step moves toward the target.
module msu_fade_ch (
    input  logic       clkin,
    input  logic       rst,
    input  logic       tick,
    input  logic       target_we,
    input  logic [7:0] target_data,
    input  logic       rate_we,
    input  logic [7:0] rate_data,
    output logic [7:0] volume,
    output logic [7:0] rate,
    output logic       change
);

    logic [7:0] target;
    logic [7:0] target_nx;
    logic [7:0] cnt;
    logic       jump;
    logic       step_due;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        target_nx = target_we ? target_data : target;
        jump      = target_we && (rate == 8'd0);
        step_due  = tick && (cnt <= 8'd1) && (volume != target_nx);
        change    = jump ? (target_data != volume) : step_due;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clkin) begin
        if (rst) begin
            target <= '0;
            volume <= '0;
            rate   <= '0;
            cnt    <= '0;
        end else begin
            if (target_we) target <= target_data;

            if (rate_we) begin
                rate <= rate_data;
                cnt  <= rate_data;
            end else if (tick) begin
                cnt <= (cnt <= 8'd1) ? rate : cnt - 8'd1;
            end

            // A new target mid-fade keeps stepping from wherever volume is now.
            if (jump)
                volume <= target_data;
            else if (step_due)
                volume <= (volume < target_nx) ? volume + 8'd1 : volume - 8'd1;
        end
    end

endmodule

// File: rtl/msu_mc.sv
// Multi-channel MSU register engine: SNES register window, data-port address,
// per-channel track/ctrl/status, fades and the MCU channel-select handshake.
module msu_mc
    import msu_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int CHW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int BUF_AW        = 14,
    parameter int REG_AW        = 4,
    parameter int FADE_PRESCALE = 21477
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic              enable,
    input  logic [REG_AW-1:0] reg_addr,
    input  logic [7:0]        reg_data_in,
    output logic [7:0]        reg_data_out,
    input  logic              reg_oe_falling,
    input  logic              reg_we_rising,
    output logic [BUF_AW-1:0] buf_rd_addr,
    input  logic [7:0]        buf_rd_data,
    input  logic [BUF_AW-1:0] buf_addr_ext,
    input  logic              buf_addr_ext_we,
    input  logic [CHW-1:0]    mcu_ch_sel,
    output logic [31:0]       addr_out,
    output logic [15:0]       track_out,
    output logic [7:0]        volume_out,
    output logic              volume_latch_out,
    output logic [7:0]        status_out,
    input  logic [5:0]        status_reset_bits,
    input  logic [5:0]        status_set_bits,
    input  logic              status_reset_we
);

    localparam int PW = (FADE_PRESCALE > 1) ? $clog2(FADE_PRESCALE) : 1;

    logic [PW-1:0]     pre_cnt;
    logic              tick;
    logic [2:0]        ext_hist;
    logic [2:0]        stat_hist;
    logic              ext_ev;
    logic              stat_ev;
    logic              rd;
    logic              wr;
    logic [3:0]        off;
    logic [CHW-1:0]    snes_ch_sel;
    logic [CHW-1:0]    sel_req;
    logic [BUF_AW-1:0] buf_addr;
    logic              data_busy;
    logic              data_start;
    logic [NUM_CH-1:0] audio_busy;
    logic [NUM_CH-1:0] audio_start;
    logic [NUM_CH-1:0] audio_error;
    logic [NUM_CH-1:0] ctrl_start;
    logic [NUM_CH-1:0] vol_dirty;
    logic [NUM_CH-1:0] vol_change;
    logic [15:0]       track        [NUM_CH];
    logic [2:0]        ctrl         [NUM_CH];
    logic [1:0]        audio_status [NUM_CH];
    logic [7:0]        volume       [NUM_CH];
    logic [7:0]        fade_rate    [NUM_CH];

    assign tick    = (pre_cnt == PW'(FADE_PRESCALE - 1));
    assign ext_ev  = (ext_hist[2:1] == 2'b01);
    assign stat_ev = (stat_hist[2:1] == 2'b01);
    assign rd      = enable & reg_oe_falling;
    assign wr      = enable & reg_we_rising;
    assign off     = 4'(reg_addr);
    assign sel_req = reg_data_in[CHW-1:0];

    assign buf_rd_addr = buf_addr;
    assign track_out   = track[mcu_ch_sel];
    assign volume_out  = volume[mcu_ch_sel];
    assign status_out  = {buf_addr[BUF_AW-1], audio_start[mcu_ch_sel], data_start,
                          vol_dirty[mcu_ch_sel], ctrl[mcu_ch_sel], ctrl_start[mcu_ch_sel]};

    always_ff @(posedge clkin) begin
        if (rst || tick) pre_cnt <= '0;
        else             pre_cnt <= pre_cnt + 1'b1;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        msu_fade_ch u_fade (
            .clkin       (clkin),
            .rst         (rst),
            .tick        (tick),
            .target_we   (wr && (off == WR_VOLUME) && (snes_ch_sel == CHW'(g))),
            .target_data (reg_data_in),
            .rate_we     (wr && (off == WR_FADE_RATE) && (snes_ch_sel == CHW'(g))),
            .rate_data   (reg_data_in),
            .volume      (volume[g]),
            .rate        (fade_rate[g]),
            .change      (vol_change[g])
        );
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            ext_hist         <= '0;
            stat_hist        <= '0;
            reg_data_out     <= '0;
            addr_out         <= '0;
            buf_addr         <= '0;
            snes_ch_sel      <= '0;
            data_busy        <= 1'b1;
            data_start       <= 1'b0;
            audio_busy       <= '1;
            audio_start      <= '0;
            audio_error      <= '0;
            ctrl_start       <= '0;
            vol_dirty        <= '0;
            volume_latch_out <= 1'b0;
            // NOTE: these per-channel arrays are architectural state, so they are cleared like any other flop.
            for (int i = 0; i < NUM_CH; i++) begin
                track[i]        <= '0;
                ctrl[i]         <= '0;
                audio_status[i] <= '0;
            end
        end else begin
            ext_hist         <= {ext_hist[1:0], buf_addr_ext_we};
            stat_hist        <= {stat_hist[1:0], status_reset_we};
            volume_latch_out <= vol_change[mcu_ch_sel];

            // An MCU reload beats the post-read increment in the same cycle.
            if (ext_ev)
                buf_addr <= buf_addr_ext;
            else if (rd && (off == RD_DATA))
                buf_addr <= buf_addr + 1'b1;

            if (rd) begin
                case (off)
                    RD_STATUS:    reg_data_out <= {data_busy, audio_busy[snes_ch_sel],
                                                   audio_status[snes_ch_sel],
                                                   audio_error[snes_ch_sel], MSU_REV};
                    RD_DATA:      reg_data_out <= buf_rd_data;
                    RD_CH_SEL:    reg_data_out <= 8'(snes_ch_sel);
                    RD_NUM_CH:    reg_data_out <= 8'(NUM_CH);
                    RD_FADE_RATE: reg_data_out <= fade_rate[snes_ch_sel];
                    default:      reg_data_out <= id_byte(off);
                endcase
            end

            if (stat_ev) begin
                audio_busy[mcu_ch_sel]   <= (audio_busy[mcu_ch_sel] | status_set_bits[ST_AUDIO])
                                            & ~status_reset_bits[ST_AUDIO];
                data_busy                <= (data_busy | status_set_bits[ST_DATA])
                                            & ~status_reset_bits[ST_DATA];
                audio_error[mcu_ch_sel]  <= (audio_error[mcu_ch_sel] | status_set_bits[ST_ERROR])
                                            & ~status_reset_bits[ST_ERROR];
                audio_status[mcu_ch_sel] <= (audio_status[mcu_ch_sel]
                                             | status_set_bits[ST_STATUS_HI:ST_STATUS_LO])
                                            & ~status_reset_bits[ST_STATUS_HI:ST_STATUS_LO];
                ctrl_start[mcu_ch_sel]   <= (ctrl_start[mcu_ch_sel] | status_set_bits[ST_CTRL_START])
                                            & ~status_reset_bits[ST_CTRL_START];
                if (status_reset_bits[ST_AUDIO]) audio_start[mcu_ch_sel] <= 1'b0;
                if (status_reset_bits[ST_DATA])  data_start              <= 1'b0;
            end

            for (int i = 0; i < NUM_CH; i++) begin
                if (stat_ev && (mcu_ch_sel == CHW'(i))) vol_dirty[i] <= 1'b0;
                if (vol_change[i])                      vol_dirty[i] <= 1'b1;
            end

            // Sits after the status update so a register write wins on a shared flag.
            if (wr) begin
                case (off)
                    WR_ADDR0: addr_out[7:0]   <= reg_data_in;
                    WR_ADDR1: addr_out[15:8]  <= reg_data_in;
                    WR_ADDR2: addr_out[23:16] <= reg_data_in;
                    WR_ADDR3: begin
                        addr_out[31:24] <= reg_data_in;
                        data_start      <= 1'b1;
                        data_busy       <= 1'b1;
                    end
                    WR_TRACK_LO: track[snes_ch_sel][7:0] <= reg_data_in;
                    WR_TRACK_HI: begin
                        track[snes_ch_sel][15:8] <= reg_data_in;
                        audio_start[snes_ch_sel] <= 1'b1;
                        audio_busy[snes_ch_sel]  <= 1'b1;
                    end
                    WR_CTRL: begin
                        if (!audio_busy[snes_ch_sel]) begin
                            ctrl[snes_ch_sel]       <= reg_data_in[2:0];
                            ctrl_start[snes_ch_sel] <= 1'b1;
                        end
                    end
                    WR_CH_SEL: snes_ch_sel <= (int'(sel_req) >= NUM_CH) ? CHW'(NUM_CH - 1) : sel_req;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_msu_mc.sv
// Self-checking bench for msu_mc: register-map vector table, hand-written
// handshake/fade/collision sequences and a randomized register-file model.
module tb_msu_mc;

    localparam int NUM_CH = 3;
    localparam int FP     = 4;
    localparam int BUF_AW = 14;

    logic              clkin = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic [3:0]        reg_addr = '0;
    logic [7:0]        reg_data_in = '0;
    logic [7:0]        reg_data_out;
    logic              reg_oe_falling = 1'b0;
    logic              reg_we_rising = 1'b0;
    logic [BUF_AW-1:0] buf_rd_addr;
    logic [7:0]        buf_rd_data;
    logic [BUF_AW-1:0] buf_addr_ext = '0;
    logic              buf_addr_ext_we = 1'b0;
    logic [1:0]        mcu_ch_sel = '0;
    logic [31:0]       addr_out;
    logic [15:0]       track_out;
    logic [7:0]        volume_out;
    logic              volume_latch_out;
    logic [7:0]        status_out;
    logic [5:0]        status_reset_bits = '0;
    logic [5:0]        status_set_bits = '0;
    logic              status_reset_we = 1'b0;

    int total = 0;
    int bad   = 0;

    msu_mc #(.NUM_CH(NUM_CH), .BUF_AW(BUF_AW), .REG_AW(4), .FADE_PRESCALE(FP)) dut (
        .clkin             (clkin),
        .rst               (rst),
        .enable            (enable),
        .reg_addr          (reg_addr),
        .reg_data_in       (reg_data_in),
        .reg_data_out      (reg_data_out),
        .reg_oe_falling    (reg_oe_falling),
        .reg_we_rising     (reg_we_rising),
        .buf_rd_addr       (buf_rd_addr),
        .buf_rd_data       (buf_rd_data),
        .buf_addr_ext      (buf_addr_ext),
        .buf_addr_ext_we   (buf_addr_ext_we),
        .mcu_ch_sel        (mcu_ch_sel),
        .addr_out          (addr_out),
        .track_out         (track_out),
        .volume_out        (volume_out),
        .volume_latch_out  (volume_latch_out),
        .status_out        (status_out),
        .status_reset_bits (status_reset_bits),
        .status_set_bits   (status_set_bits),
        .status_reset_we   (status_reset_we)
    );

    always #5 clkin = ~clkin;

    // Bench-side buffer contents: a fixed function of the byte address.
    function automatic logic [7:0] buf_byte(input int a);
        logic [7:0] lo;
        lo = 8'(a);
        return lo ^ 8'hA5;
    endfunction
    assign buf_rd_data = buf_byte(int'(buf_rd_addr));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [7:0] d, input logic en = 1'b1);
        @(negedge clkin);
        enable = en; reg_addr = a; reg_data_in = d; reg_we_rising = 1'b1;
        @(negedge clkin);
        reg_we_rising = 1'b0; enable = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] a, output logic [7:0] d);
        @(negedge clkin);
        enable = 1'b1; reg_addr = a; reg_oe_falling = 1'b1;
        @(negedge clkin);
        reg_oe_falling = 1'b0; enable = 1'b0;
        d = reg_data_out;
    endtask

    task automatic status_edge(input logic [1:0] ch, input logic [5:0] set_b, input logic [5:0] clr_b);
        @(negedge clkin);
        mcu_ch_sel = ch; status_set_bits = set_b; status_reset_bits = clr_b; status_reset_we = 1'b1;
        @(negedge clkin);
        status_reset_we = 1'b0;
        repeat (3) @(negedge clkin);
    endtask

    task automatic ext_edge(input logic [BUF_AW-1:0] a);
        @(negedge clkin);
        buf_addr_ext = a; buf_addr_ext_we = 1'b1;
        @(negedge clkin);
        buf_addr_ext_we = 1'b0;
        repeat (3) @(negedge clkin);
    endtask

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] r;
    logic [7:0] d;
    int         op;
    int         k;
    int         sel_m;
    logic [15:0] track_m [NUM_CH];
    logic [7:0]  rate_m  [NUM_CH];
    logic [31:0] addr_m;
    int          pulse_cyc[$];
    logic [7:0]  pulse_vol[$];
    int          found;

    initial begin
        // Register-map vectors from reset: reads carry expectations, writes set up state.
        vecs.push_back('{1'b0, 4'd0,  8'h00, 8'hC2});
        vecs.push_back('{1'b0, 4'd2,  8'h00, 8'h53});
        vecs.push_back('{1'b0, 4'd3,  8'h00, 8'h2D});
        vecs.push_back('{1'b0, 4'd4,  8'h00, 8'h4D});
        vecs.push_back('{1'b0, 4'd5,  8'h00, 8'h53});
        vecs.push_back('{1'b0, 4'd6,  8'h00, 8'h55});
        vecs.push_back('{1'b0, 4'd7,  8'h00, 8'h31});
        vecs.push_back('{1'b0, 4'd8,  8'h00, 8'h00});
        vecs.push_back('{1'b0, 4'd9,  8'h00, 8'(NUM_CH)});
        vecs.push_back('{1'b0, 4'd10, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 4'd11, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 4'd15, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 4'd0,  8'h78, 8'h00});
        vecs.push_back('{1'b1, 4'd1,  8'h56, 8'h00});
        vecs.push_back('{1'b1, 4'd2,  8'h34, 8'h00});
        vecs.push_back('{1'b1, 4'd3,  8'h12, 8'h00});
        vecs.push_back('{1'b1, 4'd8,  8'h03, 8'h00});
        vecs.push_back('{1'b0, 4'd8,  8'h00, 8'(NUM_CH - 1)});
        vecs.push_back('{1'b1, 4'd9,  8'h5A, 8'h00});
        vecs.push_back('{1'b0, 4'd10, 8'h00, 8'h5A});
        vecs.push_back('{1'b1, 4'd8,  8'h00, 8'h00});
        vecs.push_back('{1'b0, 4'd10, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 4'd10, 8'hFF, 8'h00});
        vecs.push_back('{1'b1, 4'd15, 8'hFF, 8'h00});
        vecs.push_back('{1'b0, 4'd10, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 4'd8,  8'h00, 8'h00});

        repeat (3) @(negedge clkin);
        rst = 1'b0;
        @(negedge clkin);
        check("rst_data_out", reg_data_out, 8'h00);
        check("rst_status_out", status_out, 8'h00);
        check("rst_addr_out", addr_out, 32'h0);
        check("rst_volume", volume_out, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) begin
                reg_write(vecs[i].addr, vecs[i].data);
            end else begin
                reg_read(vecs[i].addr, r);
                check($sformatf("vec%0d_rd%0d", i, vecs[i].addr), r, vecs[i].exp);
            end
        end
        check("addr_bytes", addr_out, 32'h12345678);
        check("data_start_set", status_out, 8'h20);
        reg_write(4'd0, 8'hFF, 1'b0);
        check("enable_low_write", addr_out, 32'h12345678);

        // Data port: wrap at the top of the buffer.
        ext_edge(14'd16383);
        check("buf_msb_hi", status_out[7], 1'b1);
        reg_read(4'd1, r);
        check("buf_rd_top", r, buf_byte(16383));
        check("buf_msb_lo", status_out[7], 1'b0);
        reg_read(4'd1, r);
        check("buf_rd_wrap", r, buf_byte(0));

        // External reload lands in the same cycle as a data-port read.
        @(negedge clkin);
        buf_addr_ext = 14'd100; buf_addr_ext_we = 1'b1;
        @(negedge clkin);
        buf_addr_ext_we = 1'b0;
        @(negedge clkin);
        enable = 1'b1; reg_addr = 4'd1; reg_oe_falling = 1'b1;
        @(negedge clkin);
        reg_oe_falling = 1'b0; enable = 1'b0;
        check("collide_rd_old", reg_data_out, buf_byte(1));
        reg_read(4'd1, r);
        check("collide_no_inc", r, buf_byte(100));

        // Audio busy/start handshake on channel 2.
        reg_write(4'd8, 8'd2);
        reg_write(4'd5, 8'h12);
        mcu_ch_sel = 2'd2;
        @(negedge clkin);
        check("audio_start2", status_out[6], 1'b1);
        check("track2", track_out, 16'h1200);
        status_edge(2'd2, 6'b000000, 6'b100000);
        reg_read(4'd0, r);
        check("busy2_clr", r, 8'h82);
        check("start2_clr", status_out[6], 1'b0);
        reg_write(4'd8, 8'd0);
        reg_read(4'd0, r);
        check("busy0_kept", r, 8'hC2);

        // Ctrl writes are gated by audio busy.
        mcu_ch_sel = 2'd0;
        reg_write(4'd7, 8'd5);
        check("ctrl_ignored", status_out[3:0], 4'h0);
        status_edge(2'd0, 6'b000000, 6'b100000);
        reg_write(4'd7, 8'd5);
        check("ctrl_taken", status_out[3:0], 4'hB);
        status_edge(2'd0, 6'b001110, 6'b000000);
        reg_read(4'd0, r);
        check("err_status_set", r, 8'hBA);
        status_edge(2'd0, 6'b000000, 6'b001110);
        reg_read(4'd0, r);
        check("err_status_clr", r, 8'h82);

        // Data busy: clear, then a write to 3 colliding with a clearing edge.
        status_edge(2'd0, 6'b000000, 6'b010000);
        reg_read(4'd0, r);
        check("data_busy_clr", r, 8'h02);
        check("data_start_clr", status_out[5], 1'b0);
        @(negedge clkin);
        status_reset_bits = 6'b010000; status_set_bits = '0; status_reset_we = 1'b1;
        @(negedge clkin);
        status_reset_we = 1'b0;
        @(negedge clkin);
        enable = 1'b1; reg_addr = 4'd3; reg_data_in = 8'h12; reg_we_rising = 1'b1;
        @(negedge clkin);
        reg_we_rising = 1'b0; enable = 1'b0;
        repeat (2) @(negedge clkin);
        reg_read(4'd0, r);
        check("write_wins_busy", r, 8'h82);
        check("write_wins_start", status_out[5], 1'b1);

        // Timed fade on channel 1: 0 -> 3, one step per FP*rate cycles.
        mcu_ch_sel = 2'd1;
        reg_write(4'd8, 8'd1);
        reg_write(4'd9, 8'd2);
        reg_write(4'd6, 8'd3);
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (volume_latch_out) begin
                pulse_cyc.push_back(cyc);
                pulse_vol.push_back(volume_out);
            end
            @(negedge clkin);
        end
        check("fade_pulses", pulse_cyc.size(), 3);
        if (pulse_cyc.size() == 3) begin
            for (int i = 0; i < 3; i++)
                check($sformatf("fade_vol%0d", i), pulse_vol[i], 8'(i + 1));
            check("fade_gap1", pulse_cyc[1] - pulse_cyc[0], FP * 2);
            check("fade_gap2", pulse_cyc[2] - pulse_cyc[1], FP * 2);
        end
        check("fade_hold", volume_out, 8'd3);
        check("vol_dirty_set", status_out[4], 1'b1);
        status_edge(2'd1, 6'b000000, 6'b000000);
        check("vol_dirty_clr", status_out[4], 1'b0);

        // Zero rate: target write jumps volume at once.
        reg_write(4'd9, 8'd0);
        reg_write(4'd6, 8'h40);
        check("jump_vol", volume_out, 8'h40);
        check("jump_latch", volume_latch_out, 1'b1);
        @(negedge clkin);
        check("jump_latch_end", volume_latch_out, 1'b0);

        // Randomized register-file traffic against a plain array model.
        for (int ch = 0; ch < NUM_CH; ch++) begin
            reg_write(4'd8, 8'(ch));
            reg_write(4'd4, 8'h00);
            reg_write(4'd5, 8'h00);
            reg_write(4'd9, 8'h00);
            track_m[ch] = '0;
            rate_m[ch]  = '0;
        end
        for (int b = 0; b < 4; b++) reg_write(4'(b), 8'h00);
        addr_m = '0;
        reg_write(4'd8, 8'd0);
        sel_m = 0;
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 5);
            d  = 8'($urandom);
            case (op)
                0: begin
                    reg_write(4'd8, d);
                    sel_m = (int'(d[1:0]) > NUM_CH - 1) ? NUM_CH - 1 : int'(d[1:0]);
                end
                1: begin reg_write(4'd4, d); track_m[sel_m][7:0]  = d; end
                2: begin reg_write(4'd5, d); track_m[sel_m][15:8] = d; end
                3: begin reg_write(4'd9, d); rate_m[sel_m] = d; end
                4: begin
                    reg_read(4'd10, r);
                    check("rand_rate", r, rate_m[sel_m]);
                    reg_read(4'd8, r);
                    check("rand_sel", r, 8'(sel_m));
                end
                default: begin
                    k = $urandom_range(0, 3);
                    reg_write(4'(k), d);
                    addr_m[8*k +: 8] = d;
                    check("rand_addr", addr_out, addr_m);
                end
            endcase
            mcu_ch_sel = 2'($urandom_range(0, NUM_CH - 1));
            @(negedge clkin);
            check("rand_track", track_out, track_m[mcu_ch_sel]);
        end

        // Reset in the middle of a fade.
        mcu_ch_sel = 2'd1;
        reg_write(4'd8, 8'd1);
        reg_write(4'd9, 8'd1);
        reg_write(4'd6, 8'h50);
        found = 0;
        for (int cyc = 0; cyc < 20 && found == 0; cyc++) begin
            if (volume_latch_out) found = 1;
            else @(negedge clkin);
        end
        check("midfade_step_seen", found, 1);
        rst = 1'b1;
        @(negedge clkin);
        check("rst_mid_vol", volume_out, 8'h00);
        check("rst_mid_latch", volume_latch_out, 1'b0);
        rst = 1'b0;
        @(negedge clkin);
        check("rst_after_latch", volume_latch_out, 1'b0);
        repeat (10) @(negedge clkin);
        check("rst_after_vol", volume_out, 8'h00);
        check("rst_after_status", status_out, 8'h00);
        reg_read(4'd0, r);
        check("rst_after_rd0", r, 8'hC2);
        reg_read(4'd8, r);
        check("rst_after_sel", r, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
